// File: rtl/wishbone_to_native_mem_reg.sv
// ============================================================================
//  Module      : wishbone_to_native_mem_reg
//  Description : Registered Wishbone-classic to native-memory bridge.
//                Latches each request, pulses data_valid_o for one cycle,
//                waits for data_valid_i and returns a one-cycle ack.
//                Define WB_NATIVE_TIMEOUT_EN to add a WAIT-state timeout
//                that answers with o_wb_err and all-ones read data.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module wishbone_to_native_mem_reg #(
  parameter int address_width  = 16,
  parameter int data_width     = 32,
  parameter int timeout_cycles = 255,
  localparam int SEL_W = data_width / 8,
  localparam int LSB   = $clog2(data_width / 8)
) (
  input  logic                       i_wb_clk,
  input  logic                       i_wb_rst,
  input  logic [address_width-1:LSB] i_wb_adr,
  input  logic [data_width-1:0]      i_wb_dat,
  input  logic [SEL_W-1:0]           i_wb_sel,
  input  logic                       i_wb_we,
  input  logic                       i_wb_cyc,
  output logic [data_width-1:0]      o_wb_rdt,
  output logic                       o_wb_ack,
  output logic                       o_wb_err,
  output logic [address_width-1:0]   address_o,
  output logic [data_width-1:0]      data_o,
  input  logic [data_width-1:0]      data_i,
  output logic [SEL_W-1:0]           write_strb_o,
  output logic                       data_valid_o,
  input  logic                       data_valid_i
);

  // Only 32/64-bit buses and a non-zero timeout make sense.
  if ((data_width != 32 && data_width != 64) || timeout_cycles < 1) begin : g_param_check
    $error("wishbone_to_native_mem_reg: illegal data_width or timeout_cycles");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic [address_width-1:0]   r_addr;
  logic [data_width-1:0]      r_wdata;
  logic [SEL_W-1:0]           r_strb;
  logic [data_width-1:0]      r_rdt;
  logic                       r_ack;
  logic                       r_abort;   // master dropped cyc during this transaction
  logic                       w_pending;
  logic                       w_capture;
  logic                       w_expire;

  assign w_pending = (r_state == S_REQ) || (r_state == S_WAIT);
  assign w_capture = w_pending && data_valid_i;

`ifdef WB_NATIVE_TIMEOUT_EN
  localparam int CNT_W = $clog2(timeout_cycles + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // Count WAIT cycles; the counter sits at zero outside WAIT so it is clear on entry.
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      r_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  // Expiry on the last allowed WAIT cycle; a simultaneous response takes priority.
  assign w_expire = (r_state == S_WAIT) && !data_valid_i &&
                    (r_cnt == CNT_W'(timeout_cycles - 1));
  assign o_wb_err = r_err;
`else
  assign w_expire = 1'b0;
  assign o_wb_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: one REQ cycle, optional WAIT, one RESP cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_wb_cyc) w_next = S_REQ;
      S_REQ:   w_next = data_valid_i ? S_RESP : S_WAIT;
      S_WAIT:  if (w_capture || w_expire) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch, response capture and registered ack/err generation.
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_strb  <= '0;
      r_rdt   <= '0;
      r_ack   <= 1'b0;
      r_abort <= 1'b0;
`ifdef WB_NATIVE_TIMEOUT_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_ack <= 1'b0;
`ifdef WB_NATIVE_TIMEOUT_EN
      r_err <= 1'b0;
`endif
      if (r_state == S_IDLE && i_wb_cyc) begin
        r_addr  <= {i_wb_adr, {LSB{1'b0}}};
        r_wdata <= i_wb_dat;
        r_strb  <= i_wb_we ? i_wb_sel : '0;
        r_abort <= 1'b0;
      end
      if (w_pending && !i_wb_cyc) begin
        r_abort <= 1'b1;
      end
      // The native side always completes; only the Wishbone answer is gated.
      if (w_capture) begin
        r_rdt  <= data_i;
        r_strb <= '0;
        r_ack  <= i_wb_cyc && !r_abort;
      end else if (w_expire) begin
        r_rdt  <= '1;
        r_strb <= '0;
`ifdef WB_NATIVE_TIMEOUT_EN
        r_err  <= i_wb_cyc && !r_abort;
`endif
      end
    end
  end

  assign address_o    = r_addr;
  assign data_o       = r_wdata;
  assign write_strb_o = r_strb;
  assign o_wb_rdt     = r_rdt;
  assign o_wb_ack     = r_ack;
  assign data_valid_o = (r_state == S_REQ);

endmodule

`default_nettype wire

// File: tb/tb_wishbone_to_native_mem_reg.sv
// ============================================================================
//  Module      : tb_wishbone_to_native_mem_reg
//  Description : Directed self-checking bench for wishbone_to_native_mem_reg
//                (32-bit instance with timeout_cycles=8, plus a 64-bit one).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_wishbone_to_native_mem_reg;

  logic        clk;
  logic        rst;

  // 32-bit instance
  logic [15:2] adr32;
  logic [31:0] dat32, rdt32, datao32, din32;
  logic [3:0]  sel32, strb32;
  logic        we32, cyc32, ack32, err32, dvo32, dvi32;
  logic [15:0] addr32;

  // 64-bit instance
  logic [15:3] adr64;
  logic [63:0] dat64, rdt64, datao64, din64;
  logic [7:0]  sel64, strb64;
  logic        we64, cyc64, ack64, err64, dvo64, dvi64;
  logic [15:0] addr64;

  int checks   = 0;
  int failures = 0;
  int n_ack;

  logic [31:0] exp_q[$];
  logic [15:0] addr_q[$];

  wishbone_to_native_mem_reg #(
    .address_width(16), .data_width(32), .timeout_cycles(8)
  ) dut32 (
    .i_wb_clk(clk), .i_wb_rst(rst), .i_wb_adr(adr32), .i_wb_dat(dat32),
    .i_wb_sel(sel32), .i_wb_we(we32), .i_wb_cyc(cyc32), .o_wb_rdt(rdt32),
    .o_wb_ack(ack32), .o_wb_err(err32), .address_o(addr32), .data_o(datao32),
    .data_i(din32), .write_strb_o(strb32), .data_valid_o(dvo32),
    .data_valid_i(dvi32)
  );

  wishbone_to_native_mem_reg #(
    .address_width(16), .data_width(64), .timeout_cycles(8)
  ) dut64 (
    .i_wb_clk(clk), .i_wb_rst(rst), .i_wb_adr(adr64), .i_wb_dat(dat64),
    .i_wb_sel(sel64), .i_wb_we(we64), .i_wb_cyc(cyc64), .o_wb_rdt(rdt64),
    .o_wb_ack(ack64), .o_wb_err(err64), .address_o(addr64), .data_o(datao64),
    .data_i(din64), .write_strb_o(strb64), .data_valid_o(dvo64),
    .data_valid_i(dvi64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One 32-bit transfer, entered at a negedge with the bridge idle.
  // lat = cycles after data_valid_o before the slave answers (0 = in REQ).
  // drop = master releases cyc in the first WAIT cycle (needs lat >= 1).
  task automatic xfer32(input logic [15:2] adr, input logic we, input logic [3:0] sel,
                        input logic [31:0] dat, input logic [31:0] din,
                        input int lat, input logic drop);
    cyc32 = 1'b1; adr32 = adr; we32 = we; sel32 = sel; dat32 = dat;
    din32 = din;  dvi32 = 1'b0;
    if (!drop) exp_q.push_back(din);
    @(negedge clk);
    chk("req_dvo",  dvo32,  1);
    chk("req_addr", addr32, {adr, 2'b00});
    chk("req_strb", strb32, we ? sel : 4'h0);
    chk("req_data", datao32, dat);
    chk("req_ack",  ack32,  0);
    if (lat == 0) dvi32 = 1'b1;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk("wait_dvo",  dvo32,  0);
      chk("wait_ack",  ack32,  0);
      chk("wait_addr", addr32, {adr, 2'b00});
      if (drop && k == 1) cyc32 = 1'b0;
      if (k == lat) dvi32 = 1'b1;
    end
    @(negedge clk);
    dvi32 = 1'b0; cyc32 = 1'b0;
    chk("resp_ack",  ack32,  drop ? 1'b0 : 1'b1);
    chk("resp_err",  err32,  0);
    chk("resp_strb", strb32, 0);
    if (!drop) chk("resp_rdt", rdt32, exp_q.pop_front());
    else       chk("drop_rdt", rdt32, din);
    @(negedge clk);
    chk("idle_ack", ack32, 0);
    chk("idle_dvo", dvo32, 0);
  endtask

  initial begin
    rst = 1'b1;
    adr32 = '0; dat32 = '0; sel32 = '0; we32 = 1'b0; cyc32 = 1'b0; din32 = '0; dvi32 = 1'b0;
    adr64 = '0; dat64 = '0; sel64 = '0; we64 = 1'b0; cyc64 = 1'b0; din64 = '0; dvi64 = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_ack",  ack32,  0);
    chk("rst_err",  err32,  0);
    chk("rst_dvo",  dvo32,  0);
    chk("rst_addr", addr32, 0);
    chk("rst_strb", strb32, 0);
    chk("rst_rdt",  rdt32,  0);
    chk("rst_ack64", ack64, 0);
    rst = 1'b0;
    @(negedge clk);

    // Read, slave answers 2 cycles after the request strobe
    xfer32(14'h0010, 1'b0, 4'hF, 32'h0, 32'hCAFEBABE, 2, 1'b0);
    // Write answered inside REQ (write also captures data_i)
    xfer32(14'h0123, 1'b1, 4'b0101, 32'hDEADBEEF, 32'h0BADF00D, 0, 1'b0);

    // 64-bit write answered in REQ
    cyc64 = 1'b1; we64 = 1'b1; sel64 = 8'h0F; dat64 = 64'h1122334455667788;
    adr64 = 13'h0123; din64 = 64'hFEEDFACE00000001; dvi64 = 1'b0;
    @(negedge clk);
    chk("w64_dvo",  dvo64,  1);
    chk("w64_strb", strb64, 8'h0F);
    chk("w64_data", datao64, 64'h1122334455667788);
    chk("w64_addr", addr64, 16'h0918);
    chk("w64_ack_early", ack64, 0);
    dvi64 = 1'b1;
    @(negedge clk);
    dvi64 = 1'b0; cyc64 = 1'b0;
    chk("w64_ack",  ack64,  1);
    chk("w64_strb_clr", strb64, 0);
    chk("w64_rdt",  rdt64,  64'hFEEDFACE00000001);
    @(negedge clk);
    chk("w64_ack_drop", ack64, 0);

    // Zero-wait slave, back-to-back reads at word addresses 1, 2, 3
    cyc32 = 1'b1; we32 = 1'b0; dvi32 = 1'b1; adr32 = 14'd1; din32 = 32'hA0000001;
    exp_q.push_back(32'hA0000001); addr_q.push_back(16'h0004);
    n_ack = 0;
    for (int c = 1; c <= 12 && n_ack < 3; c++) begin
      @(negedge clk);
      if (dvo32) chk("b2b_addr", addr32, addr_q.pop_front());
      if (ack32) begin
        chk("b2b_rdt", rdt32, exp_q.pop_front());
        chk("b2b_ack_cycle", c, 2 + 3 * n_ack);
        n_ack++;
        if (n_ack < 3) begin
          adr32 = 14'(n_ack + 1);
          din32 = 32'hA0000001 + 32'(n_ack);
          exp_q.push_back(32'hA0000001 + 32'(n_ack));
          addr_q.push_back(16'(4 * (n_ack + 1)));
        end else begin
          cyc32 = 1'b0;
        end
      end
    end
    chk("b2b_acks", n_ack, 3);
    dvi32 = 1'b0;
    @(negedge clk);

    // Stuck slave
    cyc32 = 1'b1; we32 = 1'b0; adr32 = 14'h0005; din32 = 32'h12345678; dvi32 = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
`ifdef WB_NATIVE_TIMEOUT_EN
      chk("tmo_err", err32, (i == 10) ? 1'b1 : 1'b0);
      chk("tmo_ack", ack32, 0);
      if (i == 10) begin
        chk("tmo_rdt", rdt32, 32'hFFFFFFFF);
        cyc32 = 1'b0;
      end
`else
      chk("stall_err", err32, 0);
      chk("stall_dvo", dvo32, (i == 1) ? 1'b1 : 1'b0);
`endif
    end
`ifndef WB_NATIVE_TIMEOUT_EN
    dvi32 = 1'b1; exp_q.push_back(32'h12345678);
    @(negedge clk);
    dvi32 = 1'b0; cyc32 = 1'b0;
    chk("stall_ack", ack32, 1);
    chk("stall_rdt", rdt32, exp_q.pop_front());
    @(negedge clk);
`endif

    // Asynchronous reset while in WAIT
    cyc32 = 1'b1; we32 = 1'b1; sel32 = 4'hF; dat32 = 32'h55AA55AA;
    adr32 = 14'h00AB; din32 = 32'h0; dvi32 = 1'b0;
    repeat (3) @(negedge clk);
    chk("prerst_strb", strb32, 4'hF);
    #2 rst = 1'b1;
    #1;
    chk("arst_addr", addr32, 0);
    chk("arst_data", datao32, 0);
    chk("arst_strb", strb32, 0);
    chk("arst_dvo",  dvo32,  0);
    chk("arst_ack",  ack32,  0);
    chk("arst_err",  err32,  0);
    chk("arst_rdt",  rdt32,  0);
    cyc32 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_dvo", dvo32, 0);
    xfer32(14'h0020, 1'b0, 4'h0, 32'h0, 32'h600DF00D, 1, 1'b0);

    // cyc dropped during WAIT, then a normal transaction
    xfer32(14'h0030, 1'b0, 4'hF, 32'h0, 32'h77777777, 2, 1'b1);
    xfer32(14'h0031, 1'b1, 4'h3, 32'h1234ABCD, 32'h0, 1, 1'b0);

    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wishbone_to_native_mem_reg.md
Name: wishbone_to_native_mem_reg

Overview:
- Registered, parametrised Wishbone-classic to native-memory bridge. Sits between a SERV/picorv32-class Wishbone master and native peripherals/memory.
- Generalises the combinational bridge in three ways:
  - configurable data width;
  - registered request and response, which breaks the timing path;
  - single-cycle request pulse plus explicit response wait, with an optional bus-timeout error.

Parameters:
- address_width, 16, byte-address width of the native side.
- data_width, 32, data bus width; legal values 32 or 64.
- timeout_cycles, 255, WAIT-state cycles before a timeout error; used only with the macro, minimum 1.
- Derived (localparam): SEL_W = data_width/8; LSB = log2(SEL_W).

Ports:
- i_wb_clk  in  1  clock.
- i_wb_rst  in  1  asynchronous, active-high reset.
- i_wb_adr  in  address_width-LSB  word address, occupying bits [address_width-1:LSB].
- i_wb_dat  in  data_width  write data.
- i_wb_sel  in  SEL_W  byte selects.
- i_wb_we  in  1  write enable.
- i_wb_cyc  in  1  cycle request (no separate stb).
- o_wb_rdt  out  data_width  read data.
- o_wb_ack  out  1  transfer acknowledge.
- o_wb_err  out  1  timeout error.
- address_o  out  address_width  byte address = {adr, LSB zeros}.
- data_o  out  data_width  write data.
- data_i  in  data_width  read data from native side.
- write_strb_o  out  SEL_W  byte write strobes; all zero for reads.
- data_valid_o  out  1  request strobe.
- data_valid_i  in  1  native response valid.

Behaviour:
- Reset: clock is i_wb_clk; reset is asynchronous, active-high on i_wb_rst. All outputs are 0 during reset, and the FSM enters IDLE.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - If i_wb_cyc=1, register on the same edge:
    - address_o <= {i_wb_adr, 0};
    - data_o <= i_wb_dat;
    - write_strb_o <= i_wb_we ? i_wb_sel : 0.
  - Then go to REQ.
- REQ (exactly one cycle):
  - data_valid_o=1.
  - If data_valid_i=1 in this cycle: capture data_i into o_wb_rdt and go to RESP.
  - Otherwise go to WAIT.
- WAIT:
  - data_valid_o=0; address, data and strobes are held.
  - On data_valid_i=1: capture data_i into o_wb_rdt and go to RESP.
- RESP (one cycle):
  - o_wb_ack=1; write_strb_o is cleared.
  - Then go to IDLE.
- o_wb_rdt is held until the next capture. Writes also capture data_i; the master ignores it.
- Minimum latency: cyc sampled to ack asserted is 3 cycles (IDLE edge, REQ, RESP).
- data_valid_i outside REQ/WAIT is ignored.
- i_wb_cyc dropped mid-transaction: the transaction still completes on the native side, but o_wb_ack is suppressed in RESP.
- o_wb_ack and o_wb_err are never both 1. Neither is asserted for two consecutive cycles.
- One transaction is outstanding at a time. Back-to-back transfers: cyc high in IDLE after RESP starts a new transaction.
- Asynchronous reset mid-transaction aborts it immediately: data_valid_o and ack drop, and no response is produced.

Optional Feature:
- Macro: WB_NATIVE_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When the counter reaches timeout_cycles with no data_valid_i: go to RESP with o_wb_err=1, o_wb_ack=0, and o_wb_rdt = all ones.
  - If data_valid_i arrives in the same cycle as expiry, the response wins (normal ack).
- Not defined:
  - No counter is built; WAIT waits indefinitely.
  - o_wb_err is tied to 0.

Test Plan:
- Read, data_width=32, slave responds 2 cycles after data_valid_o, cyc=1, adr=0x0010, we=0, data_i=0xCAFEBABE:
  - address_o=0x0040 and write_strb_o=0;
  - data_valid_o high for exactly 1 cycle;
  - ack one cycle with o_wb_rdt=0xCAFEBABE.
- Write, data_width=64, sel=0x0F, dat=0x1122334455667788:
  - write_strb_o=0x0F and data_o matches;
  - ack 3 cycles after cyc when the slave responds in REQ.
- Zero-wait slave (data_valid_i tied 1): back-to-back reads at adr 1, 2, 3 give 3 acks, each 3 cycles apart, with correct addresses 0x4, 0x8, 0xC.
- Stuck slave (data_valid_i=0), WB_NATIVE_TIMEOUT_EN defined, timeout_cycles=8:
  - o_wb_err pulses once after 8 WAIT cycles;
  - o_wb_rdt=0xFFFFFFFF and ack stays 0.
- Reset asserted asynchronously while in WAIT:
  - all outputs go to 0 immediately;
  - after release, a new read completes normally.
- cyc dropped during WAIT, then data_valid_i:
  - no ack;
  - FSM returns to IDLE;
  - the next transaction is correct.
